pulse_stretcher: RTL

- Converts single-cycle pulses, such as the debounced one-shot pulses from the button/switch front end, into timed output levels.
- Each accepted pulse yields one high window of HOLD_CYCLES followed by a low gap of GAP_CYCLES. Example loads are a door/arrival LED, a buzzer, or a visible floor-step indicator.
- Pulses arriving while a window or gap is in progress are queued in a saturating counter and replayed in order. No pulse is silently merged.

---
 rtl/pulse_stretcher.sv | 86 ++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle pulses into queued HOLD-high / GAP-low windows
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4000000,
  parameter int GAP_CYCLES  = 4000000,
  parameter int CNT_W       = 22,
  parameter int PEND_W      = 4
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              pulse_in,
  input  logic              flush,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PEND_W-1:0] pend_n, pend_inc;
  logic ovf_n, done, full;
  assign done = cnt == '0;
  assign full = pending == PEND_MAX;
  assign pend_inc = full ? pending : pending + 1'b1;
  assign busy = state != IDLE;
  // next state, counter, queue and overflow; a pulse coinciding with a replay consumes its own slot
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pend_n = pending;
    ovf_n = overflow;
    if (flush) begin
      state_n = IDLE;
      cnt_n = '0;
      pend_n = '0;
      ovf_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (pulse_in || pending != '0) begin
          state_n = HOLD;
          cnt_n = HOLD_LD;
          pend_n = pulse_in ? pending : pending - 1'b1;
        end
        HOLD: begin
          state_n = done ? GAP : HOLD;
          cnt_n = done ? GAP_LD : cnt - 1'b1;
          pend_n = pulse_in ? pend_inc : pending;
          ovf_n = overflow | (pulse_in & full);
        end
        GAP: if (done && (pending != '0 || pulse_in)) begin
          state_n = HOLD;
          cnt_n = HOLD_LD;
          pend_n = pulse_in ? pending : pending - 1'b1;
        end else begin
          state_n = done ? IDLE : GAP;
          cnt_n = done ? '0 : cnt - 1'b1;
          pend_n = pulse_in ? pend_inc : pending;
          ovf_n = overflow | (pulse_in & full);
        end
        default: begin
          state_n = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end
  // state registers; level_out registered from the next state so it is high exactly while in HOLD
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      pending <= '0;
      overflow <= 1'b0;
      level_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= pend_n;
      overflow <= ovf_n;
      level_out <= state_n == HOLD;
    end
  end
endmodule
